tile_config_regs: RTL

TILE_CONFIG_REGS -- requirements
Module: tile_config_regs

---
 rtl/tile_config_regs.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tile_config_regs.sv
// Tile runtime configuration register bank with host read/write channels.
// Define CFG_SHADOW_EN for shadowed config applied through a tile-idle-gated commit.
module tile_config_regs #(
  parameter int N_REGS     = 16,
  parameter int DATA_WIDTH = 32,
  parameter int VERSION    = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         reg_wvalid,
  output logic                         reg_wready,
  input  logic [7:0]                   reg_waddr,
  input  logic [DATA_WIDTH-1:0]        reg_wdata,
  input  logic                         reg_arvalid,
  output logic                         reg_arready,
  input  logic [7:0]                   reg_araddr,
  output logic                         reg_rvalid,
  input  logic                         reg_rready,
  output logic [DATA_WIDTH-1:0]        reg_rdata,
  input  logic                         tile_idle,
  output logic [N_REGS*DATA_WIDTH-1:0] cfg_out,
  output logic                         cfg_updated,
  output logic                         commit_pending
);

  localparam logic [7:0] ADDR_VERSION = 8'hFC;
  localparam logic [7:0] ADDR_STATUS  = 8'hFE;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [N_REGS-1:0]     wr_sel;
  logic [DATA_WIDTH-1:0] active_q [N_REGS];
  logic [DATA_WIDTH-1:0] rd_view  [N_REGS];
  logic                  upd_d;
  logic                  cfg_updated_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  assign wr_acc      = reg_wvalid & reg_wready;
  assign reg_arready = !rvalid_q | reg_rready;
  assign rd_acc      = reg_arvalid & reg_arready;

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
    assign wr_sel[gi] = wr_acc && (reg_waddr == 8'(gi));
    assign cfg_out[gi*DATA_WIDTH +: DATA_WIDTH] = active_q[gi];
  end

`ifdef CFG_SHADOW_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_APPLY} state_e;

  state_e                state_q;
  state_e                state_d;
  logic                  commit_acc;
  logic [DATA_WIDTH-1:0] shadow_q [N_REGS];

  assign commit_acc     = wr_acc && (reg_waddr == 8'hFD);
  assign commit_pending = (state_q != ST_IDLE);
  assign reg_wready     = !commit_pending;
  assign upd_d          = (state_q == ST_APPLY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (commit_acc) state_d = ST_WAIT;
      ST_WAIT:  if (tile_idle)  state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wr_sel[i])            shadow_q[i] <= reg_wdata;
        if (state_q == ST_APPLY)  active_q[i] <= shadow_q[i];
      end
    end
  end

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_view
    assign rd_view[gi] = shadow_q[gi];
  end
`else
  // Direct mode: the tile is assumed to tolerate live config changes.
  logic unused_tile_idle;
  assign unused_tile_idle = tile_idle;
  assign commit_pending   = 1'b0;
  assign reg_wready       = 1'b1;
  assign upd_d            = |wr_sel;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REGS; i++) active_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wr_sel[i]) active_q[i] <= reg_wdata;
      end
    end
  end

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_view
    assign rd_view[gi] = active_q[gi];
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (reg_araddr == ADDR_VERSION)     rdata_d = DATA_WIDTH'(VERSION);
    else if (reg_araddr == ADDR_STATUS) rdata_d = DATA_WIDTH'(commit_pending);
    for (int i = 0; i < N_REGS; i++) begin
      if (reg_araddr == 8'(i)) rdata_d = rd_view[i];
    end
  end

  // rdata only reloads on acceptance, so it stays stable while the host stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      cfg_updated_q <= 1'b0;
    end else begin
      cfg_updated_q <= upd_d;
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (reg_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign reg_rvalid  = rvalid_q;
  assign reg_rdata   = rdata_q;
  assign cfg_updated = cfg_updated_q;

endmodule
